// File: rtl/mod_mult_interleaved_if.sv
// rtl/mod_mult_interleaved_if.sv - operand/result handshake bundle for mod_mult_interleaved
//
// Purpose: groups the operand handshake (in_valid/in_ready, a, b, n) and the
//          result handshake (out_valid/out_ready, result, err) of the modular
//          multiplier.
// Modports:
//   master - operand producer / result consumer
//   slave  - the multiplier itself
interface mod_mult_interleaved_if #(
    parameter int WIDTH = 256
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output in_valid, a, b, n, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, a, b, n, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/mod_mult_interleaved.sv
// rtl/mod_mult_interleaved.sv - sequential (a*b) mod n by MSB-first interleaved shift-add
//
// Purpose: accepts a, b, n (a < n, b < n, n >= 2), walks b from MSB to LSB for
//          exactly WIDTH cycles folding acc = 2*acc + b[i]*a back below n each
//          cycle, then presents result = (a*b) mod n until out_ready.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mod_mult_interleaved_if.slave: in_valid/in_ready, a, b, n,
//           out_valid/out_ready, result, err
// Optional feature: define MOD_MULT_RANGE_CHECK_EN to flag a >= n or b >= n at
//          accept (err=1, result forced to 0). Without it err is tied 0.
module mod_mult_interleaved #(
    parameter int WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mod_mult_interleaved_if.slave  bus
);
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_in_ready;
    logic             w_out_valid;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;

    // t < 3n always holds for in-range operands, so WIDTH+2 bits never wrap.
    logic [WIDTH+1:0] w_t;
    logic [WIDTH+1:0] w_n1;
    logic [WIDTH+1:0] w_n2;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_accept;
    logic             w_last;
    logic             w_err;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == '0);
    assign w_n1     = {2'b00, r_n};
    assign w_n2     = {1'b0, r_n, 1'b0};

    // One interleaved step: double, conditionally add a, then at most one
    // subtraction of n or 2n brings the value back below n.
    always_comb begin
        w_t = {1'b0, r_acc, 1'b0} + (r_b[r_cnt] ? {2'b00, r_a} : '0);
        if (w_t >= w_n2) begin
            w_acc_next = WIDTH'(w_t - w_n2);
        end else if (w_t >= w_n1) begin
            w_acc_next = WIDTH'(w_t - w_n1);
        end else begin
            w_acc_next = WIDTH'(w_t);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_next = RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_n   <= bus.n;
            r_acc <= '0;
            r_cnt <= CNT_LAST;
        end else if (r_state == RUN) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_result <= w_err ? '0 : w_acc_next;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

`ifdef MOD_MULT_RANGE_CHECK_EN
    logic r_err;

    // Flag is captured at accept so it describes the operands actually latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= (bus.a >= bus.n) || (bus.b >= bus.n);
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.err       = w_err;
endmodule

// File: tb/tb_mod_mult_interleaved.sv
// tb/tb_mod_mult_interleaved.sv - self-checking bench for mod_mult_interleaved (WIDTH 8 and 256)
module tb_mod_mult_interleaved;
    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_mult_interleaved_if #(.WIDTH(8))   bus8();
    mod_mult_interleaved_if #(.WIDTH(256)) bus256();

    mod_mult_interleaved #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    mod_mult_interleaved #(.WIDTH(256)) dut256 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus256)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [8:0]   q8[$];
    logic [256:0] q256[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] ref_mod(input logic [255:0] a, input logic [255:0] b,
                                              input logic [255:0] n);
        logic [511:0] p;
        p = {256'b0, a} * {256'b0, b};
        return 256'(p % {256'b0, n});
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                       input logic [7:0] exp, input logic exp_err, input int hold);
        int         lat;
        logic       rdy_low;
        logic       stable;
        logic [8:0] e;
        logic [7:0] held;
        q8.push_back({exp_err, exp});
        bus8.a = a; bus8.b = b; bus8.n = n; bus8.in_valid = 1'b1;
        lat = 0;
        while (!bus8.in_ready && lat < 20) begin step(); lat++; end
        check("op8_accept_ready", 256'(bus8.in_ready), 1);
        step();
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.n = 8'($urandom);
        lat = 0; rdy_low = 1'b1;
        while (!bus8.out_valid && lat < 40) begin
            if (bus8.in_ready) rdy_low = 1'b0;
            step(); lat++;
        end
        check("op8_latency", 256'(lat), 8);
        check("op8_ready_low_run", 256'(rdy_low), 1);
        check("op8_ready_low_done", 256'(bus8.in_ready), 0);
        e = q8.pop_front();
        check("op8_result", 256'(bus8.result), 256'(e[7:0]));
        check("op8_err", 256'(bus8.err), 256'(e[8]));
        held = bus8.result; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus8.in_valid = (i % 3 == 0);
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.n = 8'd251;
            step();
            if (!bus8.out_valid || bus8.result !== held || bus8.in_ready) stable = 1'b0;
        end
        bus8.in_valid = 1'b0;
        if (hold > 0) check("op8_backpressure_stable", 256'(stable), 1);
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;
        check("op8_drained", 256'(bus8.out_valid), 0);
        check("op8_ready_after", 256'(bus8.in_ready), 1);
        check("op8_result_kept", 256'(bus8.result), 256'(held));
    endtask

    task automatic op256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n,
                         input logic [255:0] exp);
        int           lat;
        logic [256:0] e;
        q256.push_back({1'b0, exp});
        bus256.a = a; bus256.b = b; bus256.n = n; bus256.in_valid = 1'b1;
        lat = 0;
        while (!bus256.in_ready && lat < 20) begin step(); lat++; end
        check("op256_accept_ready", 256'(bus256.in_ready), 1);
        step();
        bus256.in_valid = 1'b0;
        bus256.a = '0; bus256.b = '1;
        lat = 0;
        while (!bus256.out_valid && lat < 300) begin step(); lat++; end
        check("op256_latency", 256'(lat), 256);
        e = q256.pop_front();
        check("op256_result", bus256.result, e[255:0]);
        check("op256_err", 256'(bus256.err), 256'(e[256]));
        bus256.out_ready = 1'b1;
        step();
        bus256.out_ready = 1'b0;
        check("op256_drained", 256'(bus256.out_valid), 0);
    endtask

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.n = '0;
        bus256.in_valid = 1'b0; bus256.out_ready = 1'b0;
        bus256.a = '0; bus256.b = '0; bus256.n = '0;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 256'(bus8.in_ready), 1);
        check("rst_out_valid", 256'(bus8.out_valid), 0);
        check("rst_result", 256'(bus8.result), 0);
        check("rst_err", 256'(bus8.err), 0);
        check("rst_in_ready_256", 256'(bus256.in_ready), 1);
        rst_n = 1'b1;
        step();

        op8(8'd200, 8'd100, 8'd251, 8'd171, 1'b0, 0);
        op8(8'd250, 8'd250, 8'd251, 8'd1,   1'b0, 0);
        op8(8'd0,   8'd123, 8'd251, 8'd0,   1'b0, 0);
        op8(8'd30,  8'd40,  8'd251, 8'd196, 1'b0, 20);
`ifdef MOD_MULT_RANGE_CHECK_EN
        op8(8'd251, 8'd3,   8'd251, 8'd0,   1'b1, 0);
`endif
        op8(8'd4,   8'd3,   8'd251, 8'd12,  1'b0, 0);

        op256(256'd2, 256'd3, P256, 256'd6);
        op256(P256 - 256'd1, P256 - 256'd1, P256, 256'd1);

        bus256.a = P256 - 256'd2; bus256.b = P256 - 256'd3; bus256.n = P256;
        bus256.in_valid = 1'b1;
        step();
        bus256.in_valid = 1'b0;
        repeat (99) step();
        check("mid_run_busy", 256'(bus256.in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 256'(bus256.in_ready), 1);
        check("mid_rst_out_valid", 256'(bus256.out_valid), 0);
        check("mid_rst_result", bus256.result, 0);
        check("mid_rst_err", 256'(bus256.err), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_no_output", 256'(bus256.out_valid), 0);
        op256(256'd5, 256'd7, P256, 256'd35);

        for (int k = 0; k < 60; k++) begin
            ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ra = ra % P256;
            rb = rb % P256;
            op256(ra, rb, P256, ref_mod(ra, rb, P256));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
